// File: rtl/md_sequencer.sv
// md_sequencer: control sequencer for the shared multiply/divide datapath.
// Takes one MPY or DIV command over a req/ack handshake, then drives the
// load/step strobes, radix-4 Booth digit selects for multiply, and the
// non-restoring add/subtract, quotient-bit and remainder-fix controls
// for divide.
module md_sequencer #(
    parameter int MUL_STEPS = 13,  // Booth steps per multiply
    parameter int DIV_STEPS = 26,  // add/subtract steps per divide
    parameter int CNT_W     = 5    // must hold max(MUL_STEPS, DIV_STEPS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req,
    input  logic             op,
    input  logic             abort,
    input  logic [2:0]       mq_low,
    input  logic             div_sign,
    input  logic             divz,
    output logic             ack,
    output logic             busy,
    output logic             load,
    output logic             step,
    output logic [2:0]       booth_sel,
    output logic             div_sub,
    output logic             qbit,
    output logic             qbit_we,
    output logic             fix,
    output logic [CNT_W-1:0] step_cnt,
    output logic             done,
    output logic             dz_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    // Operation select latched at accept time.
    localparam logic OP_MUL = 1'b0;

    // Count values: *_LAST is the count shown during the final step,
    // *_TERM is the saturated count once that step has completed.
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);
    localparam logic [CNT_W-1:0] MUL_TERM = CNT_W'(MUL_STEPS);
    localparam logic [CNT_W-1:0] DIV_TERM = CNT_W'(DIV_STEPS);

    state_t           state;
    logic             op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dz_q;

    // Booth radix-4 recoding of the window {b(i+1), b(i), b(i-1)}.
    // Encoding: bit2 = negate, bits1:0 = magnitude (01 = x1, 10 = x2).
    function automatic logic [2:0] booth_decode(input logic [2:0] win);
        logic [2:0] sel;
        case (win)
            3'b001, 3'b010: sel = 3'b001;  // +1
            3'b011:         sel = 3'b010;  // +2
            3'b100:         sel = 3'b110;  // -2
            3'b101, 3'b110: sel = 3'b101;  // -1
            default:        sel = 3'b000;  // 000 / 111 -> 0
        endcase
        return sel;
    endfunction

    // Sequencer state, step counter, latched opcode and divide-by-zero flag.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            op_q  <= 1'b0;
            cnt_q <= '0;
            dz_q  <= 1'b0;
        end else if (abort && (state != S_IDLE)) begin
            // Abort beats every other transition and suppresses DONE.
            state <= S_IDLE;
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q  <= op;
                        cnt_q <= '0;
                        dz_q  <= 1'b0;  // error from the previous command ends at accept
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (op_q == OP_MUL) begin
                        state <= S_MUL;
                    end else if (divz) begin
                        // No steps are run for a zero divisor; report and finish.
                        dz_q  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_MUL: begin
                    if (cnt_q != MUL_TERM) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= MUL_LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (cnt_q != DIV_TERM) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= DIV_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    // A new request is only looked at once back in IDLE.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state register plus the datapath status inputs
    // that must act within the same cycle (Booth window, remainder sign).
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        ack       = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        booth_sel = 3'b000;
        div_sub   = 1'b0;
        qbit      = 1'b0;
        qbit_we   = 1'b0;
        fix       = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                // NOTE: ack is the only output combinational in req while
                // in IDLE, so it is qualified with reset to keep every
                // output low while resetn is asserted.
                ack = req && resetn;
            end
            S_LOAD: begin
                busy = 1'b1;
                load = 1'b1;
            end
            S_MUL: begin
                busy      = 1'b1;
                step      = 1'b1;
                booth_sel = booth_decode(mq_low);
            end
            S_DIV: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == '0) begin
                    // First step always subtracts; there is no prior bit yet.
                    div_sub = 1'b1;
                end else begin
                    // Sign of the previous partial remainder picks the next
                    // operation and is the quotient bit of the previous step.
                    div_sub = ~div_sign;
                    qbit    = ~div_sign;
                    qbit_we = 1'b1;
                end
            end
            S_FIX: begin
                busy    = 1'b1;
                qbit    = ~div_sign;
                qbit_we = 1'b1;
                fix     = div_sign;  // negative remainder needs divisor added back
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign step_cnt = cnt_q;
    assign dz_err   = dz_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed cycle-by-cycle checks of md_sequencer.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge and compared as one packed vector per cycle.
module tb_md_sequencer;

    localparam int CNT_W = 5;

    logic             clk;
    logic             resetn;
    logic             req;
    logic             op;
    logic             abort;
    logic [2:0]       mq_low;
    logic             div_sign;
    logic             divz;
    logic             ack;
    logic             busy;
    logic             load;
    logic             step;
    logic [2:0]       booth_sel;
    logic             div_sub;
    logic             qbit;
    logic             qbit_we;
    logic             fix;
    logic [CNT_W-1:0] step_cnt;
    logic             done;
    logic             dz_err;

    int checks   = 0;
    int failures = 0;

    // Bench-side model of the state carried between commands.
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_dz;

    md_sequencer #(
        .MUL_STEPS(13),
        .DIV_STEPS(26),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .op       (op),
        .abort    (abort),
        .mq_low   (mq_low),
        .div_sign (div_sign),
        .divz     (divz),
        .ack      (ack),
        .busy     (busy),
        .load     (load),
        .step     (step),
        .booth_sel(booth_sel),
        .div_sub  (div_sub),
        .qbit     (qbit),
        .qbit_we  (qbit_we),
        .fix      (fix),
        .step_cnt (step_cnt),
        .done     (done),
        .dz_err   (dz_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {ack,busy,load,step,booth_sel[2:0],div_sub,qbit,qbit_we,fix,done,dz_err,step_cnt[4:0]}
    logic [17:0] obs;
    assign obs = {ack, busy, load, step, booth_sel, div_sub, qbit, qbit_we,
                  fix, done, dz_err, step_cnt};

    function automatic logic [17:0] ev(input logic e_ack, input logic e_busy,
                                       input logic e_load, input logic e_step,
                                       input logic [2:0] e_bsel, input logic e_dsub,
                                       input logic e_qbit, input logic e_qwe,
                                       input logic e_fix, input logic e_done,
                                       input logic e_dz, input logic [4:0] e_cnt);
        return {e_ack, e_busy, e_load, e_step, e_bsel, e_dsub, e_qbit, e_qwe,
                e_fix, e_done, e_dz, e_cnt};
    endfunction

    // Booth table written out from the digit definitions.
    function automatic logic [2:0] booth_exp(input logic [2:0] w);
        case (w)
            3'd0: return 3'b000;
            3'd1: return 3'b001;
            3'd2: return 3'b001;
            3'd3: return 3'b010;
            3'd4: return 3'b110;
            3'd5: return 3'b101;
            3'd6: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample this cycle at the falling edge, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic [17:0] exp);
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul();
        req = 1'b1;
        op  = 1'b0;
        cyc("mul_ack", ev(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, exp_dz, exp_cnt));
        req    = 1'b0;
        exp_dz = 1'b0;
        cyc("mul_load", ev(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        for (int k = 0; k < 13; k++) begin
            logic [2:0] w;
            w      = 3'(k);
            mq_low = w;
            cyc($sformatf("mul_step%0d", k),
                ev(0, 1, 0, 1, booth_exp(w), 0, 0, 0, 0, 0, 0, 5'(k)));
        end
        mq_low = 3'b011;  // nonzero window must not leak into booth_sel outside MUL
        cyc("mul_done", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 5'd13));
        exp_cnt = 5'd13;
        cyc("mul_idle", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd13));
        mq_low = 3'b000;
    endtask

    task automatic run_div(input logic neg);
        req  = 1'b1;
        op   = 1'b1;
        divz = 1'b0;
        cyc("div_ack", ev(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, exp_dz, exp_cnt));
        req    = 1'b0;
        exp_dz = 1'b0;
        cyc("div_load", ev(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        for (int k = 0; k < 26; k++) begin
            logic s;
            s        = neg && (k >= 1);
            div_sign = s;
            if (k == 0)
                cyc("div_step0", ev(0, 1, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 5'd0));
            else
                cyc($sformatf("div_step%0d", k),
                    ev(0, 1, 0, 1, 3'b000, ~s, ~s, 1, 0, 0, 0, 5'(k)));
        end
        div_sign = neg;
        cyc("div_fix", ev(0, 1, 0, 0, 3'b000, 0, ~neg, 1, neg, 0, 0, 5'd26));
        div_sign = 1'b1;  // sign must not reach fix/qbit outside their states
        cyc("div_done", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 5'd26));
        exp_cnt = 5'd26;
        cyc("div_idle", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd26));
        div_sign = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        req      = 1'b0;
        op       = 1'b0;
        abort    = 1'b0;
        mq_low   = 3'b000;
        div_sign = 1'b0;
        divz     = 1'b0;
        exp_cnt  = '0;
        exp_dz   = 1'b0;

        #3;
        check("reset_vals", 32'(obs), 32'd0);
        req = 1'b1;  // ack must stay low while reset is asserted
        #1;
        check("reset_ack_gated", 32'(obs), 32'd0);
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc("idle_after_reset", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));

        // Multiply with the Booth window cycling 000..111.
        run_mul();

        // Divide with a never-negative remainder, then with a negative one from step 2.
        run_div(1'b0);
        run_div(1'b1);

        // Divide by zero: done two cycles after accept, no steps, error held.
        req = 1'b1;
        op  = 1'b1;
        cyc("dz_ack", ev(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, exp_cnt));
        req  = 1'b0;
        divz = 1'b1;
        cyc("dz_load", ev(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        divz = 1'b0;
        cyc("dz_done", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, 5'd0));
        cyc("dz_idle1", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 5'd0));
        req = 1'b1;  // level request asserted the cycle after DONE is accepted now
        op  = 1'b0;
        cyc("dz_held_at_ack", ev(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 5'd0));
        req = 1'b0;

        // That accepted multiply is aborted at its fifth step.
        cyc("ab_load", ev(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        for (int k = 0; k < 5; k++) begin
            mq_low = 3'b011;
            if (k == 4) abort = 1'b1;
            cyc($sformatf("ab_step%0d", k),
                ev(0, 1, 0, 1, 3'b010, 0, 0, 0, 0, 0, 0, 5'(k)));
        end
        abort  = 1'b0;
        mq_low = 3'b000;
        cyc("ab_idle1", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        cyc("ab_idle2", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        exp_cnt = 5'd0;
        exp_dz  = 1'b0;
        run_mul();

        // Reset pulsed during divide step 10.
        req  = 1'b1;
        op   = 1'b1;
        divz = 1'b0;
        cyc("rd_ack", ev(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, exp_cnt));
        req = 1'b0;
        cyc("rd_load", ev(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        for (int k = 0; k < 9; k++) begin
            div_sign = 1'b0;
            cyc($sformatf("rd_step%0d", k),
                ev(0, 1, 0, 1, 3'b000, 1, (k > 0), (k > 0), 0, 0, 0, 5'(k)));
        end
        @(negedge clk);
        check("rd_step9", 32'(obs), 32'(ev(0, 1, 0, 1, 3'b000, 1, 1, 1, 0, 0, 0, 5'd9)));
        #1;
        resetn = 1'b0;
        #1;
        check("rd_async_zero", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        check("rd_held_zero", 32'(obs), 32'd0);
        resetn  = 1'b1;
        exp_cnt = 5'd0;
        exp_dz  = 1'b0;
        cyc("rd_idle", ev(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0));
        run_div(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
